// File: rtl/perf_tcp_listen_fsm_if.sv
// Listen request/response streams between the listen FSM (master) and the network stack (slave).
// Plain valid/ready on both streams; the request goes FSM -> stack, the response comes back.
interface perf_tcp_listen_fsm_if #(
    parameter int PORT_BITS = 16,
    parameter int RSP_BITS  = 8
);
    logic                 m_listen_req_valid;
    logic                 m_listen_req_ready;
    logic [PORT_BITS-1:0] m_listen_req_data;
    logic                 s_listen_rsp_valid;
    logic                 s_listen_rsp_ready;
    logic [RSP_BITS-1:0]  s_listen_rsp_data;

    modport master (
        output m_listen_req_valid,
        output m_listen_req_data,
        input  m_listen_req_ready,
        input  s_listen_rsp_valid,
        input  s_listen_rsp_data,
        output s_listen_rsp_ready
    );

    modport slave (
        input  m_listen_req_valid,
        input  m_listen_req_data,
        output m_listen_req_ready,
        output s_listen_rsp_valid,
        output s_listen_rsp_data,
        input  s_listen_rsp_ready
    );
endinterface

// File: rtl/perf_tcp_listen_fsm.sv
// Turns a host GO pulse + port into one listen request, waits for the response or a timeout, holds a sticky status.
// Latency: request valid 1 cycle after GO; status visible 1 cycle after the response handshake or timeout.
// Backpressure: request held stable until ready; response ready is low only while a request is outstanding in REQ.
module perf_tcp_listen_fsm #(
    parameter int PORT_BITS      = 16,
    parameter int RSP_BITS       = 8,
    parameter int ACC_BITS       = 32,
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic [1:0]           listen_ctrl,
    input  logic [PORT_BITS-1:0] listen_port_addr,
    input  logic [1:0]           port_sts_rd,
    perf_tcp_listen_fsm_if.master lif,
    output logic                 listen_rsp_ready,
    output logic [RSP_BITS-1:0]  listen_rsp_data,
    output logic [ACC_BITS-1:0]  listen_port_acc
);

    localparam int TIMER_BITS = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TIMER_BITS-1:0] TIMER_LAST =
        TIMER_BITS'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
    localparam logic [ACC_BITS-1:0] ACC_MAX = {ACC_BITS{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_RSP = 2'd2,
        ST_DONE     = 2'd3
    } state_t;

    state_t                state_q;
    logic [PORT_BITS-1:0]  port_q;
    logic [TIMER_BITS-1:0] timer_q;
    logic                  req_vld_q;
    logic                  rsp_rdy_q;
    logic                  sts_vld_q;
    logic [RSP_BITS-1:0]   sts_dat_q;
    logic [ACC_BITS-1:0]   acc_q;

    logic go;
    logic ack;
    logic req_hs;
    logic rsp_hs;
    logic unused_ctrl_bits;

    assign go     = listen_ctrl[0];
    assign ack    = port_sts_rd[0];
    assign req_hs = req_vld_q & lif.m_listen_req_ready;
    assign rsp_hs = lif.s_listen_rsp_valid & rsp_rdy_q;

    assign unused_ctrl_bits = ^{listen_ctrl[1], port_sts_rd[1]};

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            port_q    <= '0;
            timer_q   <= '0;
            req_vld_q <= 1'b0;
            rsp_rdy_q <= 1'b0;
            sts_vld_q <= 1'b0;
            sts_dat_q <= '0;
            acc_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        port_q    <= listen_port_addr;
                        req_vld_q <= 1'b1;
                        rsp_rdy_q <= 1'b0;
                        state_q   <= ST_REQ;
                    end else begin
                        rsp_rdy_q <= 1'b1;
                    end
                end

                ST_REQ: begin
                    if (req_hs) begin
                        req_vld_q <= 1'b0;
                        rsp_rdy_q <= 1'b1;
                        timer_q   <= '0;
                        state_q   <= ST_WAIT_RSP;
                    end
                end

                // A response arriving in the timeout cycle takes precedence over the timeout.
                ST_WAIT_RSP: begin
                    if (rsp_hs) begin
                        sts_dat_q <= lif.s_listen_rsp_data;
                        sts_vld_q <= 1'b1;
                        if (lif.s_listen_rsp_data[0] && (acc_q != ACC_MAX)) begin
                            acc_q <= acc_q + ACC_BITS'(1);
                        end
                        state_q <= ST_DONE;
                    end else if (TIMEOUT_EN && (timer_q == TIMER_LAST)) begin
                        sts_dat_q <= '1;
                        sts_vld_q <= 1'b1;
                        state_q   <= ST_DONE;
                    end else begin
                        timer_q <= timer_q + TIMER_BITS'(1);
                    end
                end

                // GO here is dropped even when it coincides with the ACK.
                ST_DONE: begin
                    if (ack) begin
                        sts_vld_q <= 1'b0;
                        state_q   <= ST_IDLE;
                    end
                end

                default: begin
                    state_q   <= ST_IDLE;
                    req_vld_q <= 1'b0;
                    rsp_rdy_q <= 1'b0;
                end
            endcase
        end
    end

    assign lif.m_listen_req_valid = req_vld_q;
    assign lif.m_listen_req_data  = port_q;
    assign lif.s_listen_rsp_ready = rsp_rdy_q;
    assign listen_rsp_ready       = sts_vld_q;
    assign listen_rsp_data        = sts_dat_q;
    assign listen_port_acc        = acc_q;

    a_req_stable: assert property (@(posedge aclk) disable iff (!aresetn)
        (req_vld_q && !lif.m_listen_req_ready) |=> (req_vld_q && $stable(port_q)));

    a_sts_only_in_done: assert property (@(posedge aclk) disable iff (!aresetn)
        sts_vld_q |-> (state_q == ST_DONE));

    a_no_rsp_rdy_in_req: assert property (@(posedge aclk) disable iff (!aresetn)
        rsp_rdy_q |-> (state_q != ST_REQ));

endmodule
